// File: rtl/alu_pkg.sv
// Shared constants and Booth radix-4 digit decoding for the 8-bit ALU datapath.
package alu_pkg;

  localparam int ALU_WIDTH  = 8;
  localparam int PROD_WIDTH = 16;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // Window is {b[2i+1], b[2i], b[2i-1]}; 3'b111 is -0 and maps to ZERO.
  function automatic booth_digit_t booth_decode(input logic [2:0] win);
    booth_digit_t d;
    case (win)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One Booth radix-4 partial product: 16-bit sign-extended 0/+-A/+-2A, with
// negation left as one's complement plus a separate correction bit.
module booth_pp_gen
  import alu_pkg::*;
(
  input  logic [2:0]            win_i,
  input  logic [ALU_WIDTH-1:0]  a_i,
  output logic [PROD_WIDTH-1:0] pp_o,
  output logic                  neg_o
);

  logic [PROD_WIDTH-1:0] a_ext;
  logic [PROD_WIDTH-1:0] a_x2;
  booth_digit_t          digit;

  // Doubling after sign extension keeps the full 9-bit value (-128 -> -256).
  assign a_ext = {{(PROD_WIDTH-ALU_WIDTH){a_i[ALU_WIDTH-1]}}, a_i};
  assign a_x2  = {a_ext[PROD_WIDTH-2:0], 1'b0};
  assign digit = booth_decode(win_i);

  always_comb begin
    pp_o  = '0;
    neg_o = 1'b0;
    case (digit)
      POS1: pp_o = a_ext;
      POS2: pp_o = a_x2;
      NEG1: begin
        pp_o  = ~a_ext;
        neg_o = 1'b1;
      end
      NEG2: begin
        pp_o  = ~a_x2;
        neg_o = 1'b1;
      end
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/signed_multiplier.sv
// Two-stage pipelined 8x8 signed multiplier: operand register, then Booth
// radix-4 partial-product sum registered into Product.
module signed_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] Product
);

  localparam int NDIG = WIDTH / 2;

  logic [WIDTH-1:0]   a_q, b_q;
  logic               v_q;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               out_valid_q;

  logic [WIDTH:0]     b_ext;
  logic [2*WIDTH-1:0] pp  [NDIG];
  logic               neg [NDIG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
    end else begin
      a_q <= A;
      b_q <= B;
      v_q <= in_valid;
    end
  end

  assign b_ext = {b_q, 1'b0};

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_pp
    booth_pp_gen u_pp (
      .win_i (b_ext[2*gi+2 -: 3]),
      .a_i   (a_q),
      .pp_o  (pp[gi]),
      .neg_o (neg[gi])
    );
  end

  // Correction bits complete the two's-complement negation at each digit's weight.
  always_comb begin
    product_d = '0;
    for (int i = 0; i < NDIG; i++) begin
      product_d = product_d + (pp[i] << (2*i));
      product_d = product_d + ((2*WIDTH)'(neg[i]) << (2*i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      product_q   <= product_d;
      out_valid_q <= v_q;
    end
  end

  assign Product   = product_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_signed_multiplier.sv
// Scoreboard bench for signed_multiplier: directed vectors push expected
// products; a negedge monitor pops and checks value and latency.
module tb_signed_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  A, B;
  logic        out_valid;
  logic [15:0] Product;

  typedef struct {
    logic [15:0] p;
    int          c;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;

  logic [7:0]  va [16];
  logic [7:0]  vb [16];
  logic [15:0] ve [16];

  signed_multiplier #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .Product   (Product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid: got out_valid=1 Product=%h at cycle %0d, required no output", Product, cyc);
      end else begin
        e = sb.pop_front();
        if (Product !== e.p) begin
          n_bad++;
          $display("FAIL product: got %h, required %h (cycle %0d)", Product, e.p, cyc);
        end
        n_cmp++;
        if (cyc != e.c + 2) begin
          n_bad++;
          $display("FAIL latency: got output at cycle %0d, required cycle %0d", cyc, e.c + 2);
        end
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    A = a;
    B = b;
    e.p = p;
    e.c = cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = $urandom_range(0, 255);
      B = $urandom_range(0, 255);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (Product !== 16'h0000 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got Product=%h out_valid=%b, required 0000/0", tag, Product, out_valid);
    end
  endtask

  initial begin
    va[0]  = 8'd0;    vb[0]  = 8'd0;    ve[0]  = 16'h0000;
    va[1]  = 8'd1;    vb[1]  = 8'd1;    ve[1]  = 16'h0001;
    va[2]  = 8'd7;    vb[2]  = 8'd3;    ve[2]  = 16'h0015;
    va[3]  = 8'd8;    vb[3]  = 8'd8;    ve[3]  = 16'h0040;
    va[4]  = 8'hFF;   vb[4]  = 8'hFF;   ve[4]  = 16'h0001;
    va[5]  = 8'hFE;   vb[5]  = 8'd1;    ve[5]  = 16'hFFFE;
    va[6]  = 8'd1;    vb[6]  = 8'hFF;   ve[6]  = 16'hFFFF;
    va[7]  = 8'hF0;   vb[7]  = 8'd15;   ve[7]  = 16'hFF10;
    va[8]  = 8'hFC;   vb[8]  = 8'hFD;   ve[8]  = 16'h000C;
    va[9]  = 8'hFF;   vb[9]  = 8'hF0;   ve[9]  = 16'h0010;
    va[10] = 8'h80;   vb[10] = 8'h80;   ve[10] = 16'h4000;
    va[11] = 8'd85;   vb[11] = 8'hAA;   ve[11] = 16'hE372;
    va[12] = 8'hAA;   vb[12] = 8'd85;   ve[12] = 16'hE372;
    va[13] = 8'd85;   vb[13] = 8'd0;    ve[13] = 16'h0000;
    va[14] = 8'd127;  vb[14] = 8'd127;  ve[14] = 16'h3F01;
    va[15] = 8'h80;   vb[15] = 8'd127;  ve[15] = 16'hC080;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = 8'h00;
    B        = 8'h00;
    #12;
    check_reset_outputs("reset_state");
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Basic and sign cases: one pair every three cycles.
    for (int i = 0; i < 16; i++) begin
      issue(va[i], vb[i], ve[i]);
      idle(2);
    end

    // Streaming: back-to-back pairs.
    for (int i = 0; i < 16; i++) issue(va[i], vb[i], ve[i]);
    idle(3);

    // Bubbles: 1,0,1,0.
    issue(va[7], vb[7], ve[7]);
    idle(1);
    issue(va[10], vb[10], ve[10]);
    idle(3);

    // Reset with two pairs in flight: both must be discarded.
    issue(va[2], vb[2], ve[2]);
    issue(va[11], vb[11], ve[11]);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("reset_mid_stream");
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    #2 rst_n = 1'b1;
    idle(4);
    issue(va[8], vb[8], ve[8]);
    idle(1);

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d outstanding results, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
